// File: rtl/generateproof_hls_deadlock_monitor_if.sv
// Bundle of dependency, token and report nets between one deadlock monitor and its neighbours.
// The dl_timestamp net exists only when DL_TIMESTAMP_EN is defined.
interface generateproof_hls_deadlock_monitor_if #(
  parameter int PROC_NUM     = 8,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3
`ifdef DL_TIMESTAMP_EN
  , parameter int TS_W       = 16
`endif
);
  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]          token_in_vec;
  logic                            dl_detect_in;
  logic                            origin;
  logic                            token_clear;
  logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]             out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]         token_out_vec;
  logic                            dl_detect_out;
  logic                            dl_seen;
`ifdef DL_TIMESTAMP_EN
  logic [TS_W-1:0]                 dl_timestamp;
`endif

  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
    output dl_detect_in, origin, token_clear,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out, dl_seen
`ifdef DL_TIMESTAMP_EN
    , input dl_timestamp
`endif
  );

  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
    input  dl_detect_in, origin, token_clear,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out, dl_seen
`ifdef DL_TIMESTAMP_EN
    , output dl_timestamp
`endif
  );
endinterface

// File: rtl/generateproof_hls_deadlock_monitor.sv
// Per-process HLS dataflow deadlock monitor: merges dependency vectors, confirms persistent
// self-dependency and rotates the report token. Optional first-confirmation timestamp: DL_TIMESTAMP_EN.
module generateproof_hls_deadlock_monitor #(
  parameter int PROC_NUM       = 8,
  parameter int PROC_ID        = 0,
  parameter int IN_CHAN_NUM    = 2,
  parameter int OUT_CHAN_NUM   = 3,
  parameter int CONFIRM_CYCLES = 4
`ifdef DL_TIMESTAMP_EN
  , parameter int TS_W         = 16
`endif
) (
  input logic clock,
  input logic reset,
  generateproof_hls_deadlock_monitor_if.slave mon_if
);
  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int PTR_W = (OUT_CHAN_NUM > 1) ? $clog2(OUT_CHAN_NUM) : 1;
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SUSPECT   = 2'd1,
    ST_CONFIRMED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [PROC_NUM-1:0]     dep_q, dep_d, merged, dep;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d, idx;
  logic [PTR_W:0]          idx_wide;
  logic [OUT_CHAN_NUM-1:0] token_q, token_d;
  logic                    seen_q, seen_d;
  logic                    gate, blocked, self_dep, pass, found, dl_detect;

  always_comb begin
    merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (mon_if.in_chan_dep_vld_vec[i]) begin
        merged = merged | mon_if.in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end else begin
        merged = merged;
      end
    end
  end

  // With a deadlock already reported and no token, the stored vector stands in for the inputs.
  assign blocked  = |mon_if.proc_dep_vld_vec;
  assign gate     = ~mon_if.dl_detect_in | (|mon_if.token_in_vec);
  assign dep      = gate ? merged : dep_q;
  assign dep_d    = blocked ? dep : '0;
  assign self_dep = gate & dep[PROC_ID] & blocked;
  assign cnt_inc  = (cnt_q == CNT_W'(CONFIRM_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
  assign seen_d   = seen_q | (state_q == ST_CONFIRMED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dep_q    <= '0;
      rr_ptr_q <= PTR_W'(OUT_CHAN_NUM - 1);
      token_q  <= '0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dep_q    <= dep_d;
      rr_ptr_q <= rr_ptr_d;
      token_q  <= token_d;
      seen_q   <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (self_dep) begin
          cnt_d   = CNT_W'(1);
          state_d = (CONFIRM_CYCLES == 1) ? ST_CONFIRMED : ST_SUSPECT;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_SUSPECT: begin
        if (!self_dep) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CONFIRM_CYCLES - 1)) begin
          state_d = ST_CONFIRMED;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_CONFIRMED: begin
        // A clear request drops the report even if the cycle is still present.
        if (mon_if.token_clear || !self_dep) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_CONFIRMED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dl_detect = (state_q == ST_CONFIRMED);
  end

  // Round-robin scan starts one past the last granted channel; channel 0 is the fallback.
  assign pass = ((|mon_if.token_in_vec) & ~mon_if.token_clear) | mon_if.origin;

  always_comb begin
    token_d  = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    if (pass) begin
      for (int i = 1; i <= OUT_CHAN_NUM; i++) begin
        idx_wide = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
        if (idx_wide >= (PTR_W+1)'(OUT_CHAN_NUM)) begin
          idx_wide = idx_wide - (PTR_W+1)'(OUT_CHAN_NUM);
        end else begin
          idx_wide = idx_wide;
        end
        idx = idx_wide[PTR_W-1:0];
        if (!found && mon_if.proc_dep_vld_vec[idx]) begin
          found    = 1'b1;
          rr_ptr_d = idx;
          token_d  = OUT_CHAN_NUM'(1) << idx;
        end else begin
          found    = found;
        end
      end
      if (!found) begin
        token_d = OUT_CHAN_NUM'(1);
      end else begin
        token_d = token_d;
      end
    end else begin
      token_d = '0;
    end
  end

  assign mon_if.out_chan_dep_vld_vec = mon_if.proc_dep_vld_vec;
  assign mon_if.out_chan_dep_data    = dep_q | SELF_BIT;
  assign mon_if.token_out_vec        = token_q;
  assign mon_if.dl_detect_out        = dl_detect;
  assign mon_if.dl_seen              = seen_q;

`ifdef DL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_q;
  logic            ts_vld_q;

  // Free-running cycle counter; the first entry into CONFIRMED captures its value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
      ts_vld_q <= 1'b0;
    end else begin
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      if (!ts_vld_q && (state_q != ST_CONFIRMED) && (state_d == ST_CONFIRMED)) begin
        ts_q     <= ts_cnt_q;
        ts_vld_q <= 1'b1;
      end else begin
        ts_q     <= ts_q;
        ts_vld_q <= ts_vld_q;
      end
    end
  end

  assign mon_if.dl_timestamp = ts_q;
`endif
endmodule

// File: tb/tb_generateproof_hls_deadlock_monitor.sv
// Scoreboard bench: a behavioural model predicts post-edge outputs per driven cycle,
// the predictions are queued and compared one cycle later.
module tb_generateproof_hls_deadlock_monitor;
  localparam int PN  = 8;
  localparam int PID = 0;
  localparam int NI  = 2;
  localparam int NO  = 3;
  localparam int CC  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  generateproof_hls_deadlock_monitor_if #(.PROC_NUM(PN), .IN_CHAN_NUM(NI), .OUT_CHAN_NUM(NO)) bus ();

  generateproof_hls_deadlock_monitor #(
    .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(NI), .OUT_CHAN_NUM(NO), .CONFIRM_CYCLES(CC)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .mon_if (bus)
  );

  typedef struct {
    logic          det;
    logic          seen;
    logic [NO-1:0] tok;
    logic [PN-1:0] dep;
    logic [15:0]   ts;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model state
  bit            m_conf, m_seen, m_tsv;
  int            m_streak, m_rr;
  logic [PN-1:0] m_dep;
  logic [15:0]   m_tscnt, m_ts;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_conf = 0; m_seen = 0; m_tsv = 0; m_streak = 0; m_rr = NO - 1;
    m_dep = '0; m_tscnt = '0; m_ts = '0;
  endtask

  task automatic drive_zero();
    bus.proc_dep_vld_vec = '0; bus.in_chan_dep_vld_vec = '0; bus.in_chan_dep_data_vec = '0;
    bus.token_in_vec = '0; bus.dl_detect_in = 1'b0; bus.origin = 1'b0; bus.token_clear = 1'b0;
  endtask

  // Starts and ends at a falling edge: drive, predict, clock, compare.
  task automatic step(input logic [NO-1:0] vld, input logic [NI-1:0] ivld,
                      input logic [NI*PN-1:0] idata, input logic [NI-1:0] tok,
                      input logic dli, input logic org, input logic clr);
    logic [PN-1:0] merged, dep, dep_n;
    logic [NO-1:0] tok_n;
    bit gate, selfd, conf_n, pass, found;
    int streak_n, rr_n, k;
    exp_t e;
    bus.proc_dep_vld_vec = vld; bus.in_chan_dep_vld_vec = ivld; bus.in_chan_dep_data_vec = idata;
    bus.token_in_vec = tok; bus.dl_detect_in = dli; bus.origin = org; bus.token_clear = clr;

    gate = !dli || (tok != '0);
    merged = '0;
    for (int i = 0; i < NI; i++)
      if (((ivld >> i) & 1) != 0) merged = merged | idata[i*PN +: PN];
    dep   = gate ? merged : m_dep;
    selfd = gate && dep[PID] && (vld != '0);
    dep_n = (vld != '0) ? dep : '0;
    if (m_conf) begin
      conf_n   = selfd && !clr;
      streak_n = conf_n ? m_streak : 0;
    end else begin
      streak_n = selfd ? m_streak + 1 : 0;
      conf_n   = (streak_n >= CC);
    end
    pass = ((tok != '0) && !clr) || org;
    tok_n = '0; rr_n = m_rr; found = 0;
    if (pass) begin
      for (int s = 1; s <= NO; s++) begin
        k = (m_rr + s) % NO;
        if (!found && (((vld >> k) & 1) != 0)) begin
          found = 1; rr_n = k; tok_n = NO'(1) << k;
        end
      end
      if (!found) tok_n = NO'(1);
    end
    if (!m_conf && conf_n && !m_tsv) begin m_ts = m_tscnt; m_tsv = 1; end
    m_tscnt = m_tscnt + 16'd1;
    e.det = conf_n; e.seen = m_seen || m_conf; e.tok = tok_n;
    e.dep = dep_n | (PN'(1) << PID); e.ts = m_ts;
    sb.push_back(e);
    m_seen = e.seen; m_conf = conf_n; m_streak = streak_n; m_rr = rr_n; m_dep = dep_n;

    #1;
    chk("dep_vld_fwd", 32'(bus.out_chan_dep_vld_vec), 32'(vld));
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("dl_detect_out", 32'(bus.dl_detect_out), 32'(e.det));
      chk("dl_seen", 32'(bus.dl_seen), 32'(e.seen));
      chk("token_out_vec", 32'(bus.token_out_vec), 32'(e.tok));
      chk("out_chan_dep_data", 32'(bus.out_chan_dep_data), 32'(e.dep));
`ifdef DL_TIMESTAMP_EN
      chk("dl_timestamp", 32'(bus.dl_timestamp), 32'(e.ts));
`endif
    end
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_det"},  32'(bus.dl_detect_out), 32'd0);
    chk({tag, "_seen"}, 32'(bus.dl_seen), 32'd0);
    chk({tag, "_tok"},  32'(bus.token_out_vec), 32'd0);
    chk({tag, "_dep"},  32'(bus.out_chan_dep_data), 32'(PN'(1) << PID));
`ifdef DL_TIMESTAMP_EN
    chk({tag, "_ts"},   32'(bus.dl_timestamp), 32'd0);
`endif
  endtask

  task automatic do_reset();
    drive_zero();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  localparam logic [NI*PN-1:0] SELF_DATA = {8'h00, 8'h01};
  localparam logic [NI*PN-1:0] ZERO_DATA = {8'h00, 8'h00};

  initial begin
    drive_zero();
    model_reset();
    do_reset();

    // persistent self-dependency confirms after four cycles, then releases
    repeat (6) step(3'b001, 2'b01, SELF_DATA, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) step(3'b001, 2'b01, ZERO_DATA, 2'b00, 1'b0, 1'b0, 1'b0);

    // broken streak never confirms
    do_reset();
    repeat (2) step(3'b001, 2'b01, SELF_DATA, 2'b00, 1'b0, 1'b0, 1'b0);
    step(3'b001, 2'b01, ZERO_DATA, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) step(3'b001, 2'b01, SELF_DATA, 2'b00, 1'b0, 1'b0, 1'b0);

    // origin-driven token rotation over channels 0 and 2, then no valid channel
    do_reset();
    repeat (3) step(3'b101, 2'b00, ZERO_DATA, 2'b00, 1'b0, 1'b1, 1'b0);
    step(3'b000, 2'b00, ZERO_DATA, 2'b00, 1'b0, 1'b1, 1'b0);
    step(3'b110, 2'b00, ZERO_DATA, 2'b01, 1'b0, 1'b0, 1'b0);

    // token_clear while confirmed kills both the token and the report
    do_reset();
    repeat (4) step(3'b001, 2'b10, {8'h01, 8'h00}, 2'b00, 1'b0, 1'b0, 1'b0);
    step(3'b001, 2'b01, SELF_DATA, 2'b01, 1'b0, 1'b0, 1'b1);
    step(3'b001, 2'b00, ZERO_DATA, 2'b00, 1'b0, 1'b0, 1'b0);

    // invalid channel masks its data even with a token present; dl_detect_in holds dep_reg
    do_reset();
    repeat (2) step(3'b010, 2'b00, SELF_DATA, 2'b01, 1'b0, 1'b0, 1'b0);
    step(3'b010, 2'b01, {8'h00, 8'h81}, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (5) step(3'b010, 2'b00, ZERO_DATA, 2'b00, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a confirmation
    repeat (2) step(3'b001, 2'b01, SELF_DATA, 2'b00, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // random traffic biased toward self-dependency
    for (int n = 0; n < 300; n++) begin
      logic [NI*PN-1:0] d;
      logic [NI-1:0]    iv;
      d  = NI*PN'($urandom);
      if ($urandom_range(0, 3) != 0) d[PID] = 1'b1;
      iv = NI'($urandom);
      if ($urandom_range(0, 3) != 0) iv[0] = 1'b1;
      step(NO'($urandom_range(0, 7)), iv, d,
           ($urandom_range(0, 3) == 0) ? NI'($urandom_range(1, 3)) : '0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
